lsu_mem_responder: RTL
======================

// Module: lsu_mem_responder
// PURPOSE
// Memory-side responder for the LSU load/store request interface. It serves
// load_req/store_req from an initiator such as lsu_wrapper.
// Backing store is a single-port word array with fixed access latency.
// Round-robin arbitration between loads and stores.
// Provides a debug port for preload/readback, plus access counters.
// PARAMETERS
// DATA_W     32   word width (`FE_DATA_W)
// ADDR_W     22   request address width (`FE_ADDR_W)
// MEM_DEPTH  64   words in array; power of two; index = addr[$clog2(MEM_DEPTH)-1:0]
// LATENCY    2    cycles from grant edge to complete pulse; legal range 1..15
// PORTS
// clk             in   1       clock
// reset           in   1       asynchronous, active-high reset
// load_req        in   1       load request; held with load_addr until load_complete
// load_addr       in   ADDR_W  load word address
// load_data       out  DATA_W  read data; valid with load_complete, held until next load
// load_complete   out  1       one-cycle pulse: load done
// store_req       in   1       store request; held with addr/data until store_complete
// store_addr      in   ADDR_W  store word address
// store_data      in   DATA_W  store write data
// store_complete  out  1       one-cycle pulse: store done
// dbg_en          in   1       debug access enable; blocks new grants while high
// dbg_we          in   1       debug write strobe (acts only when dbg_en=1 and FSM IDLE)
// dbg_addr        in   ADDR_W  debug word address (same index/wrap rule)
// dbg_wdata       in   DATA_W  debug write data
// dbg_rdata       out  DATA_W  combinational read of mem[dbg index]
// busy            out  1       FSM not IDLE
// err_oob         out  1       sticky: a granted or debug addr had bits >= MEM_DEPTH set
// load_cnt        out  16      completed loads, saturates at 16'hFFFF
// store_cnt       out  16      completed stores, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async): FSM=IDLE; last_grant=STORE; wait counter=0.
//   Outputs on reset: load_complete=0, store_complete=0, load_data=0, err_oob=0,
//   load_cnt=0, store_cnt=0. Memory array is NOT cleared.
// - FSM: IDLE -> WAIT -> RESP -> COOL -> IDLE.
// - IDLE, dbg_en=0, any req=1: grant at this edge.
//   Latch op, index, data. Set err_oob if upper addr bits are nonzero.
//   Load wait counter with LATENCY-1 and go to WAIT. If LATENCY=1, go directly to RESP.
// - Arbitration when both reqs are high: grant the op opposite to last_grant,
//   then update last_grant. After reset, a simultaneous request grants the load first.
// - WAIT: decrement counter; at 0, go to RESP.
//   Complete pulse is high in the cycle LATENCY edges after the grant edge.
// - RESP (1 cycle): op-specific action.
//   Load: load_data<=mem[idx] registered at RESP entry, with load_complete=1.
//   Store: mem[idx]<=latched data at RESP entry, with store_complete=1.
//   Increment the matching counter (saturating).
// - COOL (1 cycle): reqs ignored so the initiator can drop req; then IDLE.
//   Back-to-back throughput: one access per LATENCY+2 cycles.
// - Address wrap: index uses low bits only. Addr MEM_DEPTH+3 accesses word 3 and sets err_oob.
// - Addr/data changes during WAIT are ignored; the values latched at grant are used.
// - Req dropped before complete: the access still completes and the pulse still fires.
// - dbg_en=1 in IDLE: no grants are made.
//   dbg_we writes mem at the edge; a pending req waits.
// - dbg_en=1 while busy: the in-flight access finishes; dbg writes are ignored until IDLE.
// - Reset mid-access: pulse suppressed; pending store not written.
//   Counters and err_oob are cleared.
// TESTING
// - Preload via dbg mem[0..3]={01020000,01010101,FFFFFFFF,80808080}.
//   LATENCY=2 load addr 2 -> load_complete 2 cycles after grant, load_data=FFFFFFFF, load_cnt=1.
// - Store 0x3FC to addr 0x10 -> store_complete pulse once.
//   dbg_rdata@0x10=000003FC; store_cnt=1.
// - load_req and store_req both high from reset -> load served first, then store.
//   Next simultaneous pair -> store first.
// - Load addr 0x43 (MEM_DEPTH=64) -> returns mem[3]=80808080; err_oob=1 until reset.
// - Assert reset in WAIT of a store to 0x11 -> no store_complete.
//   mem[0x11] unchanged; counters=0.
// - Drive the 4-word lsu_wrapper load/sum/store sequence.
//   Expect mem[0x10..0x13]={003,004,3FC,200}, load_cnt=4, store_cnt=4.

Source files
------------

// File: rtl/lsu_mem_responder_if.sv
// LSU load/store request bus between an initiator (master) and the memory responder (slave).
interface lsu_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 22
);
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_complete;
  logic              store_req;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic              store_complete;

  modport master (
    output load_req, load_addr, store_req, store_addr, store_data,
    input  load_data, load_complete, store_complete
  );

  modport slave (
    input  load_req, load_addr, store_req, store_addr, store_data,
    output load_data, load_complete, store_complete
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Fixed-latency single-port memory responder for LSU loads/stores, with round-robin
// arbitration on contested requests, a debug preload/readback port and access counters.
module lsu_mem_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 22,
  parameter int MEM_DEPTH = 64,
  parameter int LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_mem_responder_if.slave    bus,
  input  logic                  dbg_en,
  input  logic                  dbg_we,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  busy,
  output logic                  err_oob,
  output logic [15:0]           load_cnt,
  output logic [15:0]           store_cnt
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_COOL = 2'd3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic              op_r;
  logic              last_grant_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] load_data_r;
  logic              load_complete_r;
  logic              store_complete_r;
  logic              err_oob_r;
  logic [15:0]       load_cnt_r;
  logic [15:0]       store_cnt_r;

  logic              grant_s;
  logic              grant_op_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic              grant_oob_s;
  logic              dbg_oob_s;
  logic              dbg_write_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grant decision: only in IDLE with debug idle; contested requests alternate.
  always_comb begin
    grant_s    = 1'b0;
    grant_op_s = OP_LOAD;
    if ((state_r == ST_IDLE) && !dbg_en && (bus.load_req || bus.store_req)) begin
      grant_s = 1'b1;
      if (bus.load_req && bus.store_req) begin
        grant_op_s = ~last_grant_r;
      end else if (bus.store_req) begin
        grant_op_s = OP_STORE;
      end else begin
        grant_op_s = OP_LOAD;
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  assign grant_addr_s = (grant_op_s == OP_STORE) ? bus.store_addr : bus.load_addr;
  assign grant_oob_s  = grant_s & (|grant_addr_s[ADDR_W-1:IDX_W]);
  assign dbg_oob_s    = dbg_en & (|dbg_addr[ADDR_W-1:IDX_W]);
  assign dbg_write_s  = dbg_en & dbg_we & (state_r == ST_IDLE);

  // Access sequencer, response registers, error flag and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 4'd0;
      op_r             <= OP_LOAD;
      last_grant_r     <= OP_STORE;
      idx_r            <= '0;
      wdata_r          <= '0;
      load_data_r      <= '0;
      load_complete_r  <= 1'b0;
      store_complete_r <= 1'b0;
      err_oob_r        <= 1'b0;
      load_cnt_r       <= 16'd0;
      store_cnt_r      <= 16'd0;
    end else begin
      load_complete_r  <= 1'b0;
      store_complete_r <= 1'b0;
      if (grant_oob_s || dbg_oob_s) begin
        err_oob_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            op_r    <= grant_op_s;
            idx_r   <= grant_addr_s[IDX_W-1:0];
            wdata_r <= bus.store_data;
            if (bus.load_req && bus.store_req) begin
              last_grant_r <= grant_op_s;
            end
            if (LATENCY == 1) begin
              state_r <= ST_RESP;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (op_r == OP_LOAD) begin
            load_data_r     <= mem_r[idx_r];
            load_complete_r <= 1'b1;
            load_cnt_r      <= sat_inc(load_cnt_r);
          end else begin
            store_complete_r <= 1'b1;
            store_cnt_r      <= sat_inc(store_cnt_r);
          end
          state_r <= ST_COOL;
        end
        ST_COOL: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Backing store is never cleared; the store commit and debug writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_RESP) && (op_r == OP_STORE)) begin
      mem_r[idx_r] <= wdata_r;
    end else if (!reset && dbg_write_s) begin
      mem_r[dbg_addr[IDX_W-1:0]] <= dbg_wdata;
    end
  end

  assign bus.load_data      = load_data_r;
  assign bus.load_complete  = load_complete_r;
  assign bus.store_complete = store_complete_r;
  assign dbg_rdata          = mem_r[dbg_addr[IDX_W-1:0]];
  assign busy               = (state_r != ST_IDLE);
  assign err_oob            = err_oob_r;
  assign load_cnt           = load_cnt_r;
  assign store_cnt          = store_cnt_r;
endmodule
